// File: rtl/shl_pkg.sv
// Shared types and helpers for the sequential shift-left engine.
// Holds the FSM state encoding and the amount clamp.
package shl_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } shl_state_t;

  // Any amount at or above the width empties the word, so clamp it.
  function automatic int unsigned sat_amt(
    input int unsigned amt,
    input int unsigned width
  );
    return (amt > width) ? width : amt;
  endfunction

endpackage

// File: rtl/seq_shl_unit.sv
// Multi-cycle logical shift-left, one bit per clock.
// Valid/ready on both sides; flags ones shifted out of the top.
module seq_shl_unit
  import shl_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int AW    = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [AW-1:0]    in_amt,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_ovf,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH + 1);

  shl_state_t     state_q;
  shl_state_t     state_d;
  logic [WIDTH-1:0] data_q;
  logic           ovf_q;
  logic [CW-1:0]  cnt_q;
  logic [CW-1:0]  amt_sat;
  logic           accept;

  assign amt_sat = CW'(sat_amt(
    int'(unsigned'(in_amt)),
    WIDTH
  ));

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign accept    = in_valid && in_ready;
  assign out_data  = data_q;
  assign out_ovf   = ovf_q;

  // Next-state: zero amount skips straight to DONE.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          if (amt_sat == '0) begin
            state_d = DONE;
          end else begin
            state_d = SHIFT;
          end
        end
      end
      SHIFT: begin
        if (cnt_q == CW'(1)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register; reset drops any in-flight result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath: load on accept, one shift step per SHIFT cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q <= '0;
      ovf_q  <= 1'b0;
      cnt_q  <= '0;
    end else begin
      if (accept) begin
        data_q <= in_data;
        ovf_q  <= 1'b0;
        cnt_q  <= amt_sat;
      end else if (state_q == SHIFT) begin
        ovf_q  <= ovf_q | data_q[WIDTH-1];
        data_q <= {data_q[WIDTH-2:0], 1'b0};
        cnt_q  <= cnt_q - CW'(1);
      end
    end
  end

endmodule
